cpu_trace_monitor: RTL and testbench

- Synthesizable, parametrised successor to the lab-computer observation bench: watches the CPU's fetch stream (PC, IR, status) and records it into a circular trace buffer.
- Halts the CPU on a PC breakpoint or on a run-cycle limit.
- After halting, drains the captured entries oldest-first over a read handshake.
- Sits beside the computer top level; `halt` drives the CPU clock-enable.

---
 rtl/cpu_trace_monitor.sv | 150 +++++++++++++++
 tb/tb_cpu_trace_monitor.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/cpu_trace_monitor.sv
// CPU fetch-stream trace monitor: captures {stamp, status, pc, ir} into a circular
// buffer while running, halts on breakpoint or cycle budget, then drains oldest-first.
module cpu_trace_monitor #(
    parameter int PC_W  = 32,
    parameter int IR_W  = 32,
    parameter int DEPTH = 16,
    parameter int CYC_W = 16
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [PC_W-1:0]               pc,
    input  logic [IR_W-1:0]               ir,
    input  logic [3:0]                    status,
    input  logic                          fetch_valid,
    input  logic                          arm,
    input  logic                          clear,
    input  logic                          bp_en,
    input  logic [PC_W-1:0]               bp_addr,
    input  logic [CYC_W-1:0]              cycle_limit,
    input  logic                          rd_req,
    output logic [CYC_W+4+PC_W+IR_W-1:0]  rd_data,
    output logic                          rd_valid,
    output logic [$clog2(DEPTH):0]        count,
    output logic                          overflow,
    output logic                          halt,
    output logic [1:0]                    state
);

    localparam int ENTRY_W = CYC_W + 4 + PC_W + IR_W;
    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_HALT = 2'd2;

    logic [1:0]         state_q,    state_d;
    logic [CYC_W-1:0]   cyc_q,      cyc_d;
    logic [PTR_W-1:0]   wr_ptr_q,   wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q,   rd_ptr_d;
    logic [CNT_W-1:0]   count_q,    count_d;
    logic               overflow_q, overflow_d;
    logic [ENTRY_W-1:0] rd_data_q,  rd_data_d;
    logic               rd_valid_q, rd_valid_d;

    logic               wr_en;
    logic [ENTRY_W-1:0] wr_entry;
    logic               bp_hit;
    logic               lim_hit;

    // Trace storage is deliberately unreset; pointers and count alone define validity.
    logic [ENTRY_W-1:0] mem [DEPTH];

    assign wr_entry = {cyc_q, status, pc, ir};
    assign bp_hit   = fetch_valid & bp_en & (pc == bp_addr);
    assign lim_hit  = (cycle_limit != '0) && (cyc_q == cycle_limit - CYC_W'(1));

    always_comb begin
        state_d    = state_q;
        cyc_d      = cyc_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        wr_en      = 1'b0;

        if (clear) begin
            state_d    = S_IDLE;
            cyc_d      = '0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            overflow_d = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (arm) begin
                        state_d = S_RUN;
                        cyc_d   = '0;
                    end
                end
                S_RUN: begin
                    cyc_d = cyc_q + CYC_W'(1);
                    if (fetch_valid) begin
                        wr_en    = 1'b1;
                        wr_ptr_d = wr_ptr_q + PTR_W'(1);
                        // Full buffer: drop the oldest entry to make room.
                        if (count_q != FULL) begin
                            count_d = count_q + CNT_W'(1);
                        end else begin
                            rd_ptr_d   = rd_ptr_q + PTR_W'(1);
                            overflow_d = 1'b1;
                        end
                    end
                    if (bp_hit || lim_hit) begin
                        state_d = S_HALT;
                    end
                end
                S_HALT: begin
                    if (rd_req && (count_q != '0)) begin
                        rd_data_d  = mem[rd_ptr_q];
                        rd_valid_d = 1'b1;
                        rd_ptr_d   = rd_ptr_q + PTR_W'(1);
                        count_d    = count_q - CNT_W'(1);
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            cyc_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cyc_q      <= cyc_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_ptr_q] <= wr_entry;
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign count    = count_q;
    assign overflow = overflow_q;
    assign halt     = (state_q == S_HALT);
    assign state    = state_q;

endmodule

// File: tb/tb_cpu_trace_monitor.sv
// Directed bench for cpu_trace_monitor: capture, breakpoint, limit, overflow, drain, clear, reset.
module tb_cpu_trace_monitor;

    localparam int PC_W  = 32;
    localparam int IR_W  = 32;
    localparam int DEPTH = 16;
    localparam int CYC_W = 16;
    localparam int ENTRY_W = CYC_W + 4 + PC_W + IR_W;

    logic                   clock;
    logic                   reset;
    logic [PC_W-1:0]        pc;
    logic [IR_W-1:0]        ir;
    logic [3:0]             status;
    logic                   fetch_valid;
    logic                   arm;
    logic                   clear;
    logic                   bp_en;
    logic [PC_W-1:0]        bp_addr;
    logic [CYC_W-1:0]       cycle_limit;
    logic                   rd_req;
    logic [ENTRY_W-1:0]     rd_data;
    logic                   rd_valid;
    logic [$clog2(DEPTH):0] count;
    logic                   overflow;
    logic                   halt;
    logic [1:0]             state;

    int tests;
    int fails;

    cpu_trace_monitor #(.PC_W(PC_W), .IR_W(IR_W), .DEPTH(DEPTH), .CYC_W(CYC_W)) dut (
        .clock(clock), .reset(reset), .pc(pc), .ir(ir), .status(status),
        .fetch_valid(fetch_valid), .arm(arm), .clear(clear), .bp_en(bp_en),
        .bp_addr(bp_addr), .cycle_limit(cycle_limit), .rd_req(rd_req),
        .rd_data(rd_data), .rd_valid(rd_valid), .count(count),
        .overflow(overflow), .halt(halt), .state(state)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [ENTRY_W-1:0] entry(input int stamp, input int idx);
        logic [CYC_W-1:0] s;
        logic [3:0]       st;
        logic [PC_W-1:0]  p;
        logic [IR_W-1:0]  w;
        s  = CYC_W'(stamp);
        st = 4'(idx);
        p  = PC_W'(idx * 4);
        w  = IR_W'(32'hA500_0000 + idx);
        return {s, st, p, w};
    endfunction

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic drive_fetch(input int idx);
        fetch_valid = 1'b1;
        pc          = PC_W'(idx * 4);
        ir          = IR_W'(32'hA500_0000 + idx);
        status      = 4'(idx);
    endtask

    task automatic do_clear_arm;
        clear = 1'b1; tick; clear = 1'b0;
        arm = 1'b1; tick; arm = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b0;
        #10;
        reset = 1'b1;
        tick;
        tests++; if (state !== 2'd0) begin fails++; $display("FAIL reset_state got %0d exp 0", state); end
        tests++; if (halt !== 1'b0) begin fails++; $display("FAIL reset_halt got %0b exp 0", halt); end
        tests++; if (count !== '0) begin fails++; $display("FAIL reset_count got %0d exp 0", count); end
        tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL reset_overflow got %0b exp 0", overflow); end
        tests++; if (rd_valid !== 1'b0) begin fails++; $display("FAIL reset_rd_valid got %0b exp 0", rd_valid); end
        tests++; if (rd_data !== '0) begin fails++; $display("FAIL reset_rd_data got %h exp 0", rd_data); end
    endtask

    task automatic test_breakpoint;
        cycle_limit = '0; bp_en = 1'b1; bp_addr = 32'h0C;
        do_clear_arm;
        tests++; if (state !== 2'd1) begin fails++; $display("FAIL bp_run_state got %0d exp 1", state); end
        for (int i = 0; i < 4; i++) begin
            drive_fetch(i);
            tick;
            if (i < 3) begin
                tests++; if (state !== 2'd1) begin fails++; $display("FAIL bp_early_halt i=%0d got state %0d exp 1", i, state); end
            end
        end
        fetch_valid = 1'b0;
        tests++; if (state !== 2'd2 || halt !== 1'b1) begin fails++; $display("FAIL bp_halt got state %0d halt %0b exp 2/1", state, halt); end
        tests++; if (count !== 5'd4) begin fails++; $display("FAIL bp_count got %0d exp 4", count); end
        rd_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick;
            tests++; if (rd_valid !== 1'b1 || rd_data !== entry(i, i)) begin
                fails++; $display("FAIL bp_read%0d got v=%0b %h exp v=1 %h", i, rd_valid, rd_data, entry(i, i));
            end
        end
        rd_req = 1'b0;
        tick;
        tests++; if (count !== '0 || rd_valid !== 1'b0) begin fails++; $display("FAIL bp_drained got count %0d v %0b exp 0/0", count, rd_valid); end
    endtask

    task automatic test_overflow;
        cycle_limit = '0; bp_en = 1'b1; bp_addr = 32'h50;
        do_clear_arm;
        for (int i = 0; i <= 20; i++) begin
            drive_fetch(i);
            tick;
        end
        fetch_valid = 1'b0;
        tests++; if (state !== 2'd2) begin fails++; $display("FAIL ovf_state got %0d exp 2", state); end
        tests++; if (count !== 5'd16) begin fails++; $display("FAIL ovf_count got %0d exp 16", count); end
        tests++; if (overflow !== 1'b1) begin fails++; $display("FAIL ovf_flag got %0b exp 1", overflow); end
        rd_req = 1'b1;
        for (int k = 0; k < 16; k++) begin
            tick;
            tests++; if (rd_valid !== 1'b1 || rd_data !== entry(5 + k, 5 + k)) begin
                fails++; $display("FAIL ovf_read%0d got v=%0b %h exp v=1 %h", k, rd_valid, rd_data, entry(5 + k, 5 + k));
            end
        end
        rd_req = 1'b0;
        tick;
        tests++; if (count !== '0) begin fails++; $display("FAIL ovf_drained got %0d exp 0", count); end
    endtask

    task automatic test_halted_ctrl;
        rd_req = 1'b1; tick; rd_req = 1'b0;
        tests++; if (rd_valid !== 1'b0) begin fails++; $display("FAIL empty_read got v=%0b exp 0", rd_valid); end
        arm = 1'b1; tick; arm = 1'b0;
        tests++; if (state !== 2'd2) begin fails++; $display("FAIL halted_arm got state %0d exp 2", state); end
        clear = 1'b1; arm = 1'b1; tick; clear = 1'b0; arm = 1'b0;
        tests++; if (state !== 2'd0 || count !== '0 || overflow !== 1'b0) begin
            fails++; $display("FAIL clear got state %0d count %0d ovf %0b exp 0/0/0", state, count, overflow);
        end
        // Counter must restart at zero on the next arm.
        bp_en = 1'b1; bp_addr = 32'h1C;
        arm = 1'b1; tick; arm = 1'b0;
        drive_fetch(7); tick; fetch_valid = 1'b0;
        tests++; if (state !== 2'd2 || count !== 5'd1) begin fails++; $display("FAIL rearm_halt got state %0d count %0d exp 2/1", state, count); end
        rd_req = 1'b1; tick; rd_req = 1'b0;
        tests++; if (rd_valid !== 1'b1 || rd_data !== entry(0, 7)) begin
            fails++; $display("FAIL rearm_stamp got v=%0b %h exp v=1 %h", rd_valid, rd_data, entry(0, 7));
        end
    endtask

    task automatic test_cycle_limit;
        bp_en = 1'b0; cycle_limit = 16'd10;
        do_clear_arm;
        for (int k = 0; k < 10; k++) begin
            if (k % 2 == 0) drive_fetch(k);
            else fetch_valid = 1'b0;
            tick;
            tests++; if (halt !== (k == 9)) begin fails++; $display("FAIL limit_halt k=%0d got %0b exp %0b", k, halt, (k == 9)); end
        end
        fetch_valid = 1'b0;
        tests++; if (count !== 5'd5) begin fails++; $display("FAIL limit_count got %0d exp 5", count); end
        rd_req = 1'b1;
        for (int j = 0; j < 5; j++) begin
            tick;
            tests++; if (rd_valid !== 1'b1 || rd_data !== entry(2 * j, 2 * j)) begin
                fails++; $display("FAIL limit_read%0d got v=%0b %h exp v=1 %h", j, rd_valid, rd_data, entry(2 * j, 2 * j));
            end
        end
        rd_req = 1'b0;
        tick;
    endtask

    task automatic test_async_reset;
        bp_en = 1'b0; cycle_limit = '0;
        do_clear_arm;
        for (int i = 0; i < 7; i++) begin
            drive_fetch(i);
            tick;
        end
        fetch_valid = 1'b0;
        tests++; if (count !== 5'd7 || state !== 2'd1) begin fails++; $display("FAIL pre_reset got count %0d state %0d exp 7/1", count, state); end
        #1;
        reset = 1'b0;
        #1;
        tests++; if (count !== '0 || state !== 2'd0 || halt !== 1'b0) begin
            fails++; $display("FAIL async_reset got count %0d state %0d halt %0b exp 0/0/0", count, state, halt);
        end
        #10;
        reset = 1'b1;
        tick;
    endtask

    initial begin
        tests = 0; fails = 0;
        pc = '0; ir = '0; status = '0; fetch_valid = 1'b0; arm = 1'b0; clear = 1'b0;
        bp_en = 1'b0; bp_addr = '0; cycle_limit = '0; rd_req = 1'b0; reset = 1'b0;
        test_reset;
        test_breakpoint;
        test_overflow;
        test_halted_ctrl;
        test_cycle_limit;
        test_async_reset;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
